dmem_arbiter: RTL
=================

# dmem_arbiter

Arbiter that shares the single-port data memory between the processor's load/store port and an external port used by a DMA engine or test loader. It selects one requester per cycle and steers its address, write enable and write data to the memory. It returns read data to the winner and stalls the processor whenever the external port owns the memory. Instantiated at top level between the processor, the external master and dmem.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive locked grants to the external port while the CPU waits (≥1)
- SCW, 16, stall-counter width

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU load/store request this cycle
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  read data to CPU
- cpu_stall  out  1  CPU request not served this cycle; CPU must hold its request
- ext_req  in  1  external request; held until granted
- ext_lock  in  1  external master requests an atomic multi-cycle ownership
- ext_we, ext_addr, ext_wdata  in  1/AW/DW  external write enable, address, data
- ext_gnt  out  1  external request served this cycle
- ext_rdata  out  DW  read data to external master
- mem_we  out  1  to dmem wr_en
- mem_addr  out  AW  to dmem addr
- mem_wdata  out  DW  to dmem wr_data
- mem_rdata  in  DW  from dmem rd_data (combinational read)
- stall_cnt  out  SCW  saturating count of CPU stall cycles

## Operation
- State: mode {ARB, LOCKED}, last_winner {CPU, EXT}, burst count (width clog2(MAX_BURST+1)), stall_cnt.
- Grant selection is combinational from the requests and the registered state. Only a granted requester drives mem_*. With no grant, mem_we=0 and mem_addr/mem_wdata=0.
- ARB mode:
  - Single requester wins.
  - Both requesting: the requester that is not last_winner wins.
  - last_winner updates only on contested cycles.
- Entry to LOCKED: any cycle with ext granted and ext_lock=1. Sets count=1.
- LOCKED mode, ext_req & ext_lock both high:
  - ext wins, count increments, saturating at MAX_BURST.
  - Exception: count==MAX_BURST and cpu_req=1. Then the CPU wins (forced release), mode→ARB, count→0, last_winner→CPU.
- LOCKED mode, ext_req=0 or ext_lock=0: the cycle arbitrates under ARB rules, mode→ARB, count→0.
- cpu_stall = cpu_req & ~cpu_granted.
- ext_gnt = ext_req & ext_granted.
- cpu_rdata = ext_rdata = mem_rdata. Valid only for the granted requester.
- stall_cnt increments on each cycle with cpu_stall=1 and saturates at all-ones.
- Reset:
  - mode=ARB, last_winner=EXT (the CPU wins the first contested cycle), count=0, stall_cnt=0.
  - While rst=1: no grants, mem_we=0, cpu_stall=0, ext_gnt=0.

## Timing
- Zero-latency arbitration: grant, cpu_stall and mem_* are valid in the same cycle as the request.
- Write commits at the rising edge that ends the grant cycle.
- Read data is valid in the grant cycle, combinationally through dmem.
- Requesters hold req/we/addr/wdata stable until served. Changing them while stalled or ungranted is illegal.
- A read issued in the cycle after a granted write to the same address returns the new data.
- Simultaneous forced release and ext_lock deassert: treated as release. The CPU wins if requesting.
- rst asserted mid-LOCKED: the next cycle is ARB with count=0, and the CPU wins if contested.

## Test plan
- Reset: rst high 2 cycles with both requests high → ext_gnt=0, cpu_stall=0, mem_we=0. After release stall_cnt=0 and the first contested cycle grants the CPU.
- CPU only: write 0xDEADBEEF to 0x10, then read 0x10 → mem_we=1 in the write cycle, cpu_stall=0 throughout, cpu_rdata=0xDEADBEEF.
- Both requesting continuously, ext_lock=0 → grants C,E,C,E…; cpu_stall 0,1,0,1; stall_cnt=3 after 6 cycles.
- MAX_BURST=4, ext_lock=1, both requesting → pattern E,E,E,E,C,E,E,E,E,C; cpu_stall high exactly on E cycles.
- Lock dropped after 2 ext beats with cpu_req high → the next cycle grants the CPU, mode ARB. Assert rst during a locked burst → the CPU wins the next contested cycle.
- SCW=4, CPU stalled 20 cycles (ext locked, cpu_req held, MAX_BURST large) → stall_cnt saturates at 0xF.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the three buses around the data-memory arbiter.
//   cpu_*  : processor load/store port (req/we/addr/wdata in, rdata/stall out)
//   ext_*  : external master port (req/lock/we/addr/wdata in, gnt/rdata out)
//   mem_*  : single-port dmem (we/addr/wdata out, rdata in, combinational read)
// slave  = arbiter side, master = the surrounding requesters and memory.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          ext_req;
  logic          ext_lock;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic [DW-1:0] ext_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_lock, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the CPU load/store port
// and an external (DMA / loader) port. One winner per cycle, zero-latency.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : dmem_arbiter_if.slave (cpu_*, ext_*, mem_* signals)
//   stall_cnt : saturating count of cycles with cpu_stall high
// Arbitration alternates on contested cycles; an external lock keeps the
// memory for up to MAX_BURST beats while the CPU waits, then the CPU is
// forced in for one cycle.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int SCW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic [SCW-1:0] stall_cnt
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  typedef enum logic { ARB, LOCKED } mode_t;
  typedef enum logic { W_CPU, W_EXT } who_t;

  mode_t         mode_q, mode_d;
  who_t          lw_q, lw_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic contested, lock_cont, forced;
  logic gnt_cpu, gnt_ext, stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= ARB;
      lw_q   <= W_EXT;   // CPU takes the first contested cycle
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      lw_q   <= lw_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ext = 1'b0;
    mode_d  = ARB;
    cnt_d   = '0;
    lw_d    = lw_q;

    contested = bus.cpu_req & bus.ext_req;
    lock_cont = (mode_q == LOCKED) & bus.ext_req & bus.ext_lock;
    // burst exhausted while the CPU waits: CPU gets this cycle
    forced    = lock_cont & (cnt_q == CNT_MAX) & bus.cpu_req;

    if (!rst) begin
      if (lock_cont) begin
        gnt_cpu = forced;
        gnt_ext = ~forced;
      end else if (contested) begin
        gnt_cpu = (lw_q == W_EXT);
        gnt_ext = (lw_q == W_CPU);
      end else begin
        gnt_cpu = bus.cpu_req;
        gnt_ext = bus.ext_req;
      end
    end

    if (forced) begin
      lw_d = W_CPU;
    end else if (gnt_ext & bus.ext_lock) begin
      mode_d = LOCKED;
      if (lock_cont)
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      else
        cnt_d = CW'(1);
    end

    if (contested & (gnt_cpu | gnt_ext))
      lw_d = gnt_cpu ? W_CPU : W_EXT;
  end

  assign stall = bus.cpu_req & ~gnt_cpu & ~rst;

  // only the winner reaches the memory; idle bus is all zero
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt_cpu) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (gnt_ext) begin
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  assign bus.cpu_stall = stall;
  assign bus.ext_gnt   = bus.ext_req & gnt_ext;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ext_rdata = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + SCW'(1);
  end
endmodule
